// File: rtl/sub_share_arbiter.sv
// Round-robin arbiter that time-shares one W-bit subtractor among NUM_REQ clients.
// Each accepted request runs through IDLE -> CALC -> RESP, so at most one op every 3 cycles.
module sub_share_arbiter #(
  parameter  int W       = 8,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*W-1:0] a_in_i,
  input  logic [NUM_REQ*W-1:0] b_in_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ID_W-1:0]      done_id_o,
  output logic [W-1:0]         result_o,
  output logic                 borrow_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ID_W-1:0]      done_id_q, done_id_d;
  logic [W-1:0]         result_q, result_d;
  logic                 borrow_q, borrow_d;

  logic [NUM_REQ-1:0][W-1:0] a_arr, b_arr;
  logic                      pick_vld;
  logic [ID_W-1:0]           pick_id;
  logic [W:0]                diff;

  assign a_arr = a_in_i;
  assign b_arr = b_in_i;

  // Borrow falls out as the extra MSB of a zero-extended subtraction.
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  // Scan from ptr upward with wrap; iterating downward lets offset 0 win last.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req_i[idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    grant_d   = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    result_d  = result_q;
    borrow_d  = borrow_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          a_d     = a_arr[pick_id];
          b_d     = b_arr[pick_id];
          id_d    = pick_id;
          grant_d = NUM_REQ'(1) << pick_id;
          ptr_d   = ID_W'((int'(pick_id) + 1) % NUM_REQ);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        result_d  = diff[W-1:0];
        borrow_d  = diff[W];
        done_id_d = id_q;
        done_d    = 1'b1;
        state_d   = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      result_q  <= '0;
      borrow_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      result_q  <= result_d;
      borrow_q  <= borrow_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign done_id_o = done_id_q;
  assign result_o  = result_q;
  assign borrow_o  = borrow_q;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Randomized + directed bench for sub_share_arbiter against a cycle-level behavioural model.
module tb_sub_share_arbiter;
  localparam int W = 8, N = 4, ID_W = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   a_in_i, b_in_i;
  logic [N-1:0]     grant_o;
  logic             busy_o, done_o, borrow_o;
  logic [ID_W-1:0]  done_id_o;
  logic [W-1:0]     result_o;

  sub_share_arbiter #(.W(W), .NUM_REQ(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .a_in_i(a_in_i), .b_in_i(b_in_i),
    .grant_o(grant_o), .busy_o(busy_o), .done_o(done_o), .done_id_o(done_id_o),
    .result_o(result_o), .borrow_o(borrow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0, n_errs = 0;

  // Model: phase counts cycles since the granting edge (0 = idle).
  int m_phase, m_ptr, m_id, m_a, m_b;
  int e_grant, e_busy, e_done, e_did, e_res, e_bor;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int id;
    if (rst_i) begin
      m_phase = 0; m_ptr = 0; m_id = 0; m_a = 0; m_b = 0;
      e_grant = 0; e_busy = 0; e_done = 0; e_did = 0; e_res = 0; e_bor = 0;
      return;
    end
    e_grant = 0;
    e_done  = 0;
    if (m_phase == 0) begin
      id = -1;
      for (int k = 0; k < N; k++)
        if (id < 0 && req_i[(m_ptr + k) % N]) id = (m_ptr + k) % N;
      if (id >= 0) begin
        m_id    = id;
        m_a     = int'(a_in_i[id*W +: W]);
        m_b     = int'(b_in_i[id*W +: W]);
        e_grant = 1 << id;
        m_ptr   = (id + 1) % N;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      e_res   = (m_a - m_b + 256) % 256;
      e_bor   = (m_a < m_b) ? 1 : 0;
      e_did   = m_id;
      e_done  = 1;
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
    e_busy = (m_phase != 0) ? 1 : 0;
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later,
  // returns at the falling edge so the caller can drive the next inputs.
  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    chk("grant",   int'(grant_o),   e_grant);
    chk("busy",    int'(busy_o),    e_busy);
    chk("done",    int'(done_o),    e_done);
    chk("done_id", int'(done_id_o), e_did);
    chk("result",  int'(result_o),  e_res);
    chk("borrow",  int'(borrow_o),  e_bor);
    @(negedge clk_i);
  endtask

  task automatic set_op(input int i, input int a, input int b);
    a_in_i[i*W +: W] = W'(a);
    b_in_i[i*W +: W] = W'(b);
  endtask

  initial begin
    rst_i = 1'b1; req_i = '0; a_in_i = '0; b_in_i = '0;
    @(negedge clk_i);
    step(); step();
    rst_i = 1'b0;

    // 1: basic subtract, checked also against hard constants
    set_op(0, 200, 55); req_i = 4'b0001;
    step();
    chk("t1_grant", int'(grant_o), 1);
    req_i = '0;
    step();
    chk("t1_done", int'(done_o), 1);
    chk("t1_res", int'(result_o), 145);
    chk("t1_bor", int'(borrow_o), 0);
    step(); step();

    // 2: wrap with borrow, then equal operands
    set_op(1, 5, 10); req_i = 4'b0010;
    step(); req_i = '0; step();
    chk("t2_res", int'(result_o), 251);
    chk("t2_bor", int'(borrow_o), 1);
    chk("t2_id", int'(done_id_o), 1);
    step();
    set_op(1, 8'h80, 8'h80); req_i = 4'b0010;
    step(); req_i = '0; step();
    chk("t2_eq_res", int'(result_o), 0);
    chk("t2_eq_bor", int'(borrow_o), 0);
    step();

    // 3: all requesting, rotation
    for (int i = 0; i < N; i++) set_op(i, 10 * i + 7, i);
    req_i = 4'b1111;
    for (int c = 0; c < 15; c++) step();
    req_i = '0;
    step(); step(); step();

    // 4: after grant to id 2, req=0011 must wrap to 0 then 1
    set_op(2, 3, 1); req_i = 4'b0100;
    step();
    chk("t4_g2", int'(grant_o), 4);
    req_i = 4'b0011;
    step(); step(); step();
    chk("t4_g0", int'(grant_o), 1);
    step(); step(); step();
    chk("t4_g1", int'(grant_o), 2);
    req_i = '0;
    step(); step(); step();

    // 5: reset during CALC, pointer back to 0
    req_i = 4'b0010;
    step(); req_i = '0;
    rst_i = 1'b1;
    step();
    chk("t5_done", int'(done_o), 0);
    chk("t5_busy", int'(busy_o), 0);
    rst_i = 1'b0;
    step();
    req_i = 4'b1100;
    step();
    chk("t5_grant", int'(grant_o), 4);
    req_i = '0;
    step(); step(); step();

    // 6: short pulse during CALC is never granted; then 0-255
    req_i = 4'b0010;
    step(); req_i = 4'b0001;
    step(); req_i = '0;
    step(); step(); step();
    chk("t6_idle", int'(busy_o), 0);
    set_op(0, 0, 255); req_i = 4'b0001;
    step(); req_i = '0; step();
    chk("t6_res", int'(result_o), 1);
    chk("t6_bor", int'(borrow_o), 1);
    step();

    // random traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      req_i  = N'($urandom_range(0, (1 << N) - 1));
      a_in_i = N*W'({$urandom, $urandom});
      b_in_i = N*W'({$urandom, $urandom});
      rst_i  = ($urandom_range(0, 49) == 0);
      step();
    end
    rst_i = 1'b0; req_i = '0;
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
